// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier: WIDTH-cycle signed/unsigned multiply
// producing a full 2*WIDTH-bit product, with early-out on a zero operand.
module seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic                 is_signed,
   output logic                 busy,
   output logic [2*WIDTH-1:0]   product,
   output logic                 valid
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state_reg, state_next;
   logic [2*WIDTH-1:0] mcand_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [2*WIDTH-1:0] acc_sum;
   logic [WIDTH-1:0]   mplr_reg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [CW-1:0]      count_reg;
   logic               sign_reg;
   logic               last_iter;
   logic               zero_op;

   // Two's-complement magnitude; -2^(W-1) maps to 2^(W-1) as an unsigned value.
   always_comb begin
      mag_a     = (is_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
      mag_b     = (is_signed && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
      zero_op   = (multiplicand == '0) || (multiplier == '0);
      acc_sum   = mplr_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
      last_iter = (count_reg == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      valid      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = zero_op ? DONE : CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (last_iter) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            valid      = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_reg <= '0;
         acc_reg   <= '0;
         mplr_reg  <= '0;
         count_reg <= '0;
         sign_reg  <= 1'b0;
         product   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  mcand_reg <= {{WIDTH{1'b0}}, mag_a};
                  mplr_reg  <= mag_b;
                  acc_reg   <= '0;
                  count_reg <= '0;
                  sign_reg  <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                  if (zero_op) begin
                     product <= '0;
                  end
               end
            end
            CALC: begin
               acc_reg   <= acc_sum;
               mcand_reg <= mcand_reg << 1;
               mplr_reg  <= mplr_reg >> 1;
               count_reg <= count_reg + CW'(1);
               // Negation happens over the full 2*WIDTH bits so MULH sees a correct high half.
               if (last_iter) begin
                  product <= sign_reg ? -acc_sum : acc_sum;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
